axis_pkt_tx: RTL

Read side of the packet mover's staging FIFO. Accepts a packet-length command, pops exactly that many words from a first-word-fall-through sync FIFO, and emits them as one AXI4-Stream packet with TLAST on the final beat. A registered output stage sustains 1 beat/cycle under continuous TREADY and honours full AXI-Stream backpressure.

---
 rtl/axis_pkt_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/axis_pkt_tx.sv
// axis_pkt_tx: read side of the packet mover's staging FIFO.
// Takes a packet-length command, pops that many words from a FWFT FIFO and
// emits them as one AXI4-Stream packet through a registered output stage.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// STREAM | popping words into the output stage, beats still owed
// DRAIN  | all words popped, waiting for the TLAST beat to be taken
module axis_pkt_tx #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              pkt_done,
  output logic              err_zero_len,
  output logic [CNT_W-1:0]  pkt_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] remaining;

  logic ostage_free;
  logic beat_taken;
  logic last_taken;
  logic load;
  logic start_pkt;
  logic zero_cmd;
  logic rem_is_one;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode, command handshake and pop strobe.
  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    load        = 1'b0;
    start_pkt   = 1'b0;
    zero_cmd    = 1'b0;
    last_taken  = 1'b0;
    ostage_free = !m_axis_tvalid || m_axis_tready;
    beat_taken  = m_axis_tvalid && m_axis_tready;
    rem_is_one  = (remaining == LEN_W'(1));
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            zero_cmd = 1'b1;
          end else begin
            start_pkt = 1'b1;
            state_nxt = STREAM;
          end
        end
      end
      STREAM: begin
        // A reset cycle never pops, so the FIFO head survives an abandoned packet.
        load = (remaining != '0) && !fifo_empty && ostage_free && !rst;
        if (load && rem_is_one) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        last_taken = beat_taken && m_axis_tlast;
        if (last_taken) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign fifo_rd_en = load;
  assign busy       = (state != IDLE);

  // Beat counter, output stage and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      pkt_done      <= 1'b0;
      err_zero_len  <= 1'b0;
      pkt_count     <= '0;
    end else begin
      pkt_done     <= last_taken;
      err_zero_len <= zero_cmd;

      if (start_pkt) begin
        remaining <= cmd_len;
      end else if (load) begin
        remaining <= remaining - LEN_W'(1);
      end

      // A load in the same cycle as a handshake replaces the taken beat,
      // which keeps tvalid high for full throughput.
      if (load) begin
        m_axis_tdata  <= fifo_rd_data;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= rem_is_one;
      end else if (beat_taken) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      if (last_taken) begin
        pkt_count <= pkt_count + CNT_W'(1);
      end
    end
  end

endmodule
